// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// Single outstanding request: req/addr held until a one-cycle ack.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC owner, single-outstanding imem requester.
// IF_ALIGN_CHECK_EN adds if_excp_adel for misaligned fetch addresses.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   stall,
  input  logic         flush,
  input  logic [31:0]  new_pc,
  input  logic         branch_flag_i,
  input  logic [31:0]  branch_target_addr_i,
  inst_fetch_if.master imem,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_inst,
  output logic         if_rom_ce,
  output logic         stallreq_if
`ifdef IF_ALIGN_CHECK_EN
  ,output logic        if_excp_adel
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    VALID,
    DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req_q, req_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] ifpc_q, ifpc_n;
  logic [31:0] inst_q, inst_n;
  logic        ce_q, ce_n;
  logic        issue;
  logic [31:0] tgt;
  logic        consume;
  logic [31:0] next_pc;
  logic        unused_stall;
`ifdef IF_ALIGN_CHECK_EN
  logic        adel_q, adel_n;
`endif

  assign unused_stall = ^stall[5:2];

  assign consume = (state == VALID) && !stall[0]
                && !stall[1] && !flush;
  assign next_pc = branch_flag_i ? branch_target_addr_i
                                 : pc + 32'(PC_STEP);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = req_q;
    addr_n  = addr_q;
    ifpc_n  = ifpc_q;
    inst_n  = inst_q;
    ce_n    = ce_q;
    issue   = 1'b0;
    tgt     = pc;
`ifdef IF_ALIGN_CHECK_EN
    adel_n  = adel_q;
`endif
    unique case (state)
      IDLE: begin
        if (flush) pc_n = new_pc;
        tgt   = pc_n;
        issue = 1'b1;
      end
      REQ: begin
        if (flush) begin
          pc_n = new_pc;
          if (imem.imem_ack || !req_q) begin
            tgt   = new_pc;
            issue = 1'b1;
          end else begin
            state_n = DROP;
          end
        end else if (req_q && imem.imem_ack) begin
          state_n = VALID;
          inst_n  = imem.imem_rdata;
          ifpc_n  = pc;
          ce_n    = 1'b1;
          req_n   = 1'b0;
        end
`ifdef IF_ALIGN_CHECK_EN
        else if (!req_q) begin
          // misaligned target: no bus cycle, deliver a faulting slot
          state_n = VALID;
          inst_n  = '0;
          ifpc_n  = pc;
          ce_n    = 1'b1;
          adel_n  = 1'b1;
        end
`endif
      end
      VALID: begin
        if (flush) begin
          pc_n   = new_pc;
          ce_n   = 1'b0;
          inst_n = '0;
          tgt    = new_pc;
          issue  = 1'b1;
        end else if (consume) begin
          pc_n  = next_pc;
          ce_n  = 1'b0;
          tgt   = next_pc;
          issue = 1'b1;
        end
`ifdef IF_ALIGN_CHECK_EN
        if (issue) adel_n = 1'b0;
`endif
      end
      DROP: begin
        if (flush) pc_n = new_pc;
        if (imem.imem_ack) begin
          tgt   = pc_n;
          issue = 1'b1;
        end
      end
    endcase
    if (issue) begin
      state_n = REQ;
`ifdef IF_ALIGN_CHECK_EN
      addr_n = tgt;
      req_n  = (tgt[1:0] == 2'b00);
`else
      addr_n = tgt & 32'hFFFF_FFFC;
      req_n  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= '0;
      ifpc_q <= '0;
      inst_q <= '0;
      ce_q   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_q  <= req_n;
      addr_q <= addr_n;
      ifpc_q <= ifpc_n;
      inst_q <= inst_n;
      ce_q   <= ce_n;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) adel_q <= 1'b0;
    else        adel_q <= adel_n;
  end

  assign if_excp_adel = adel_q;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign if_pc          = ifpc_q;
  assign if_inst        = inst_q;
  assign if_rom_ce      = ce_q;
  assign stallreq_if    = (state != VALID);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch (default build).
// Each row: inputs for one cycle, outputs expected after that edge.
module tb_inst_fetch;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        sreq;
  } obs_t;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic        br;
    logic [31:0] bta;
    logic        ack;
    logic [31:0] rdata;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_addr_i = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_rom_ce;
  logic        stallreq_if;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  inst_fetch_if imem();

  inst_fetch #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .new_pc(new_pc),
    .branch_flag_i(branch_flag_i),
    .branch_target_addr_i(branch_target_addr_i),
    .imem(imem),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .if_rom_ce(if_rom_ce),
    .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.req  = imem.imem_req;
    o.addr = imem.imem_addr;
    o.ce   = if_rom_ce;
    o.pc   = if_pc;
    o.inst = if_inst;
    o.sreq = stallreq_if;
    return o;
  endfunction

  function automatic obs_t mk(logic r, logic [31:0] a, logic c,
                              logic [31:0] p, logic [31:0] i,
                              logic s);
    obs_t o;
    o.req = r; o.addr = a; o.ce = c;
    o.pc = p; o.inst = i; o.sreq = s;
    return o;
  endfunction

  task automatic check(string name, obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h ce=%b pc=%h inst=%h sreq=%b, want req=%b addr=%h ce=%b pc=%h inst=%h sreq=%b",
               name, act.req, act.addr, act.ce, act.pc, act.inst,
               act.sreq, exp.req, exp.addr, exp.ce, exp.pc,
               exp.inst, exp.sreq);
    end
  endtask

  task automatic v(logic [5:0] s, logic f, logic [31:0] np,
                   logic b, logic [31:0] bt, logic a,
                   logic [31:0] rd, logic er, logic [31:0] ea,
                   logic ec, logic [31:0] ep, logic [31:0] ei,
                   logic es);
    vec_t t;
    t.stall = s; t.flush = f; t.npc = np; t.br = b;
    t.bta = bt; t.ack = a; t.rdata = rd;
    t.exp = mk(er, ea, ec, ep, ei, es);
    tbl.push_back(t);
  endtask

  task automatic drive(logic [5:0] s, logic f, logic [31:0] np,
                       logic b, logic [31:0] bt, logic a,
                       logic [31:0] rd);
    stall = s;
    flush = f;
    new_pc = np;
    branch_flag_i = b;
    branch_target_addr_i = bt;
    imem.imem_ack = a;
    imem.imem_rdata = rd;
  endtask

  initial begin
    // zero-wait sequential fetch 0,4,8
    v(0,0,0,0,0, 0,0,          1,32'h0,0,32'h0,0,1);
    v(0,0,0,0,0, 1,32'hA0,     0,32'h0,1,32'h0,32'hA0,0);
    v(0,0,0,0,0, 0,0,          1,32'h4,0,32'h0,32'hA0,1);
    v(0,0,0,0,0, 1,32'hA4,     0,32'h4,1,32'h4,32'hA4,0);
    v(0,0,0,0,0, 0,0,          1,32'h8,0,32'h4,32'hA4,1);
    v(0,0,0,0,0, 1,32'hA8,     0,32'h8,1,32'h8,32'hA8,0);
    // branch to 0x10, ack delayed 3 cycles
    v(0,0,0,1,32'h10, 0,0,     1,32'h10,0,32'h8,32'hA8,1);
    v(0,0,0,0,0, 0,0,          1,32'h10,0,32'h8,32'hA8,1);
    v(0,0,0,0,0, 0,0,          1,32'h10,0,32'h8,32'hA8,1);
    v(0,0,0,0,0, 0,0,          1,32'h10,0,32'h8,32'hA8,1);
    v(0,0,0,0,0, 1,32'hB10,    0,32'h10,1,32'h10,32'hB10,0);
    // valid at 0x20 held under stalls
    v(0,0,0,1,32'h20, 0,0,     1,32'h20,0,32'h10,32'hB10,1);
    v(0,0,0,0,0, 1,32'hC20,    0,32'h20,1,32'h20,32'hC20,0);
    v(3,0,0,0,0, 0,0,          0,32'h20,1,32'h20,32'hC20,0);
    v(3,0,0,0,0, 0,0,          0,32'h20,1,32'h20,32'hC20,0);
    v(1,0,0,0,0, 0,0,          0,32'h20,1,32'h20,32'hC20,0);
    v(2,0,0,0,0, 0,0,          0,32'h20,1,32'h20,32'hC20,0);
    v(0,0,0,0,0, 0,0,          1,32'h24,0,32'h20,32'hC20,1);
    v(0,0,0,0,0, 1,32'hD24,    0,32'h24,1,32'h24,32'hD24,0);
    // branch 0x100, then flush beats branch
    v(0,0,0,1,32'h100, 0,0,    1,32'h100,0,32'h24,32'hD24,1);
    v(0,0,0,0,0, 1,32'hE100,   0,32'h100,1,32'h100,32'hE100,0);
    v(0,1,32'h180,1,32'h200, 0,0,
                               1,32'h180,0,32'h100,32'h0,1);
    v(0,0,0,0,0, 1,32'hF180,   0,32'h180,1,32'h180,32'hF180,0);
    // upper stall bits ignored; flush while req to 0x40 pending
    v(6'h3C,0,0,1,32'h40, 0,0, 1,32'h40,0,32'h180,32'hF180,1);
    v(0,1,32'h180,0,0, 0,0,    1,32'h40,0,32'h180,32'hF180,1);
    v(0,0,0,0,0, 0,0,          1,32'h40,0,32'h180,32'hF180,1);
    v(0,0,0,0,0, 1,32'hDEAD,   1,32'h180,0,32'h180,32'hF180,1);
    v(0,0,0,0,0, 1,32'h1180,   0,32'h180,1,32'h180,32'h1180,0);
    // flush in VALID, then flush coinciding with ack in REQ
    v(0,1,32'h300,0,0, 0,0,    1,32'h300,0,32'h180,32'h0,1);
    v(0,1,32'h400,0,0, 1,32'hBEEF,
                               1,32'h400,0,32'h180,32'h0,1);
    v(0,0,0,0,0, 1,32'h2400,   0,32'h400,1,32'h400,32'h2400,0);
    // 32-bit PC wrap
    v(0,0,0,1,32'hFFFF_FFFC, 0,0,
                               1,32'hFFFF_FFFC,0,32'h400,32'h2400,1);
    v(0,0,0,0,0, 1,32'h3FFC,   0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'h3FFC,0);
    v(0,0,0,0,0, 0,0,          1,32'h0,0,32'hFFFF_FFFC,32'h3FFC,1);
    v(0,0,0,0,0, 1,32'h4000,   0,32'h0,1,32'h0,32'h4000,0);
    // misaligned pc: addr low bits forced, pc keeps them
    v(0,0,0,1,32'h102, 0,0,    1,32'h100,0,32'h0,32'h4000,1);
    v(0,0,0,0,0, 1,32'h5102,   0,32'h100,1,32'h102,32'h5102,0);
    v(0,0,0,0,0, 0,0,          1,32'h104,0,32'h102,32'h5102,1);
    v(0,0,0,0,0, 1,32'h6106,   0,32'h104,1,32'h106,32'h6106,0);
    // stray ack with no request outstanding
    v(3,0,0,0,0, 1,32'h7777,   0,32'h104,1,32'h106,32'h6106,0);
    // repeated flush while dropping an orphan response
    v(0,0,0,1,32'h50, 0,0,     1,32'h50,0,32'h106,32'h6106,1);
    v(0,1,32'h60,0,0, 0,0,     1,32'h50,0,32'h106,32'h6106,1);
    v(0,1,32'h70,0,0, 0,0,     1,32'h50,0,32'h106,32'h6106,1);
    v(0,0,0,0,0, 1,32'hDEAD,   1,32'h70,0,32'h106,32'h6106,1);
    v(0,0,0,0,0, 1,32'h8070,   0,32'h70,1,32'h70,32'h8070,0);

    drive(0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", mk(0,32'h0,0,32'h0,32'h0,1));

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].npc, tbl[i].br,
            tbl[i].bta, tbl[i].ack, tbl[i].rdata);
      @(posedge clk);
      #1 check($sformatf("row%0d", i), tbl[i].exp);
      @(negedge clk);
    end

    // async reset while a request is outstanding
    drive(0,0,0,0,0,0,0);
    @(posedge clk);
    #1 check("pre_reset_req", mk(1,32'h74,0,32'h70,32'h8070,1));
    #2 rst_n = 1'b0;
    #1 check("async_reset", mk(0,32'h0,0,32'h0,32'h0,1));
    @(negedge clk);
    drive(0,0,0,0,0,1,32'hBAD0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("late_ack_idle", mk(1,32'h0,0,32'h0,32'h0,1));
    @(negedge clk);
    drive(0,0,0,0,0,0,0);
    @(posedge clk);
    #1 check("first_req_wait", mk(1,32'h0,0,32'h0,32'h0,1));
    @(negedge clk);
    drive(0,0,0,0,0,1,32'h9000);
    @(posedge clk);
    #1 check("first_fetch", mk(0,32'h0,1,32'h0,32'h9000,0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage. Owns the PC, issues single-outstanding requests to instruction memory over a req/ack handshake, and holds the fetched word.
- Presents if_pc/if_inst/if_rom_ce to the IF/ID pipeline register.
- Honours pipeline stall, exception flush (redirect to new_pc) and branch redirect from ID.
- Raises stallreq_if while no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment between sequential instructions.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  6  pipeline stall vector; bits [0] and [1] used, others ignored; 1 = Stop.
- flush  input  1  exception flush; redirect to new_pc.
- new_pc  input  32  exception handler address, valid with flush.
- branch_flag_i  input  1  ID-stage branch taken.
- branch_target_addr_i  input  32  branch target.
- imem_req  output  1  memory request, registered.
- imem_addr  output  32  request address, registered, stable while imem_req=1.
- imem_ack  input  1  one-cycle response strobe; data valid with it.
- imem_rdata  input  32  instruction word.
- if_pc  output  32  address of held instruction.
- if_inst  output  32  held instruction.
- if_rom_ce  output  1  1 = if_pc/if_inst valid.
- stallreq_if  output  1  fetch stall request to pipeline control, combinational from state.

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=0.
  - if_pc=0, if_inst=0, if_rom_ce=0.
  - stallreq_if=1.
- consume = (state==VALID) && stall[0]==0 && stall[1]==0 && flush==0.
- Next-PC rule on consume: branch_flag_i ? branch_target_addr_i : pc+PC_STEP, 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- States:
  - IDLE: next edge → REQ; imem_req<=1, imem_addr<=pc.
  - REQ:
    - imem_ack=1, no flush → VALID; if_inst<=imem_rdata, if_pc<=pc, if_rom_ce<=1, imem_req<=0.
    - flush with imem_ack=1 → data discarded; pc<=new_pc; stay REQ; imem_addr<=new_pc (req stays 1).
    - flush with imem_ack=0 → DROP; pc<=new_pc; imem_req held at old address until ack.
  - VALID: outputs hold.
    - flush → pc<=new_pc; if_rom_ce<=0, if_inst<=0; → REQ, imem_req<=1, imem_addr<=new_pc.
    - consume → pc<=next; if_rom_ce<=0; → REQ, imem_req<=1, imem_addr<=next.
    - Otherwise hold indefinitely.
  - DROP: waiting for orphan response.
    - flush again → pc<=new_pc, stay DROP.
    - imem_ack → data discarded; → REQ, imem_req<=1, imem_addr<=pc (latest redirect).
- Handshake:
  - Memory samples imem_addr while imem_req=1.
  - Ack may come in the same cycle as req or any later cycle.
  - imem_ack while imem_req=0 is ignored.
  - Exactly one request outstanding at any time.
- Throughput: zero-wait memory gives one instruction per 2 cycles (REQ, VALID).
- stallreq_if = (state != VALID).
- Simultaneous flush + branch_flag_i: flush wins.
- Reset mid-request: returns to IDLE. Any late ack is then in IDLE with imem_req=0 and is ignored.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Extra output port if_excp_adel (1 bit), reset 0.
  - On entering REQ with pc[1:0]!=0, no memory request is issued (imem_req stays 0). Next edge → VALID with if_inst=0, if_pc=pc, if_rom_ce=1, if_excp_adel=1.
  - if_excp_adel clears on leaving VALID.
- Undefined:
  - No port.
  - imem_addr[1:0] is forced to 2'b00; pc low bits are otherwise carried unchanged.

Test Plan:
- Reset release, memory acks same cycle, no stalls → imem_addr sequence 0,4,8; if_rom_ce pulses every 2nd cycle; if_pc 0,4,8 with matching if_inst.
- Ack delayed 3 cycles at addr 0x10 → stallreq_if=1 for those cycles; imem_addr stays 0x10; if_inst=rdata in the cycle after ack.
- Valid instr at 0x20, stall[1:0]=2'b11 for 4 cycles → if_pc/if_inst stable, no new req; then release → next req at 0x24.
- Consume with branch_flag_i=1, target 0x100 → next imem_addr=0x100; with flush also 1 and new_pc=0x180 → imem_addr=0x180.
- Flush (new_pc=0x180) while req to 0x40 pending, ack 2 cycles later with 0xDEAD → 0xDEAD never on if_inst; next req addr 0x180.
- Async reset asserted mid-request → all outputs reset immediately; late ack ignored; first req after release at RESET_PC.
